// File: rtl/alu_issue_pkg.sv
// Shared constants for alu_issue: op codes, FSM encoding, result flag layout.
package alu_issue_pkg;

   // Command op codes; everything at or above OP_ILL_LO is illegal
   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_SUB    = 3'b001;
   localparam logic [2:0] OP_AND    = 3'b010;
   localparam logic [2:0] OP_OR     = 3'b011;
   localparam logic [2:0] OP_XOR    = 3'b100;
   localparam logic [2:0] OP_CMP    = 3'b101;
   localparam logic [2:0] OP_ILL_LO = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Bit positions inside res_flags = {err, of, cf, zf}
   localparam int FLG_ZF  = 0;
   localparam int FLG_CF  = 1;
   localparam int FLG_OF  = 2;
   localparam int FLG_ERR = 3;

   function automatic logic is_illegal(input logic [2:0] op);
      return op >= OP_ILL_LO;
   endfunction

   // ALU select: cmp runs as a subtract, illegal ops park the ALU on add
   function automatic logic [2:0] alu_sel(input logic [2:0] op);
      if (op == OP_CMP)   return OP_SUB;
      if (is_illegal(op)) return OP_ADD;
      return op;
   endfunction

endpackage

// File: rtl/alu_issue_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Increment on request unless already at the maximum value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/alu_issue.sv
// Issue/response wrapper around an external ALU: latches one command,
// drives the ALU for two cycles, captures and holds the result until taken.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_m,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_zf,
   input  logic             alu_cf,
   input  logic             alu_of,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_y,
   output logic [3:0]       res_flags,
   output logic [2:0]       stat_flags,
   output logic [15:0]      op_count
);

   state_t           state;
   logic             exec_ph;   // 0: first EXEC cycle, 1: capture at end of this cycle
   logic [2:0]       op_q;
   logic [WIDTH-1:0] cap_y;
   logic [3:0]       cap_flags;
   logic             capture;

   // Capture happens on the second EXEC edge, giving the ALU a full settle cycle
   assign capture = (state == ST_EXEC) && exec_ph;

   // Result/flag shaping per op class; logic ops mask the ALU's stale cf/of
   always_comb begin
      cap_y     = '0;
      cap_flags = '0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            cap_y     = alu_y;
            cap_flags = {1'b0, alu_of, alu_cf, alu_zf};
         end
         OP_AND, OP_OR, OP_XOR: begin
            cap_y     = alu_y;
            cap_flags = {3'b000, alu_zf};
         end
         OP_CMP: begin
            cap_y     = '0;
            cap_flags = {1'b0, alu_of, alu_cf, alu_zf};
         end
         default: begin
            cap_y              = '0;
            cap_flags          = '0;
            cap_flags[FLG_ERR] = 1'b1;
         end
      endcase
   end

   // Issue FSM with registered handshake, ALU drive and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         exec_ph    <= 1'b0;
         op_q       <= OP_ADD;
         cmd_ready  <= 1'b1;
         res_valid  <= 1'b0;
         res_y      <= '0;
         res_flags  <= '0;
         stat_flags <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_m      <= OP_ADD;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  // ALU inputs only change here, so they hold steady outside EXEC
                  op_q      <= cmd_op;
                  alu_a     <= cmd_a;
                  alu_b     <= cmd_b;
                  alu_m     <= alu_sel(cmd_op);
                  exec_ph   <= 1'b0;
                  cmd_ready <= 1'b0;
                  state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (!exec_ph) begin
                  exec_ph <= 1'b1;
               end else begin
                  res_y     <= cap_y;
                  res_flags <= cap_flags;
                  res_valid <= 1'b1;
                  state     <= ST_RESP;
                  if (!is_illegal(op_q))
                     stat_flags <= cap_flags[FLG_OF:FLG_ZF];
               end
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.W(16)) u_op_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (capture && !is_illegal(op_q)),
      .count (op_count)
   );

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU that reports junk
// cf/of on logic ops, plus a small standalone saturation check.
module tb_alu_issue;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [2:0]  alu_m;
   logic        alu_zf, alu_cf, alu_of;
   logic        res_valid, res_ready;
   logic [31:0] res_y;
   logic [3:0]  res_flags;
   logic [2:0]  stat_flags;
   logic [15:0] op_count;
   logic        sc_inc;
   logic [2:0]  sc_count;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   alu_issue #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_y(alu_y),
      .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of),
      .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
      .res_flags(res_flags), .stat_flags(stat_flags), .op_count(op_count)
   );

   sat_counter #(.W(3)) u_sc (.clk(clk), .rst_n(rst_n), .inc(sc_inc), .count(sc_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: logic ops deliberately drive cf=of=1
   always_comb begin
      alu_y  = '0;
      alu_cf = 1'b0;
      alu_of = 1'b0;
      case (alu_m)
         3'b000: begin
            {alu_cf, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            alu_of = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         3'b001: begin
            alu_y  = alu_a - alu_b;
            alu_cf = alu_a < alu_b;
            alu_of = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         3'b010: begin alu_y = alu_a & alu_b; alu_cf = 1'b1; alu_of = 1'b1; end
         3'b011: begin alu_y = alu_a | alu_b; alu_cf = 1'b1; alu_of = 1'b1; end
         3'b100: begin alu_y = alu_a ^ alu_b; alu_cf = 1'b1; alu_of = 1'b1; end
         default: begin alu_y = 32'hDEAD_BEEF; alu_cf = 1'b1; alu_of = 1'b1; end
      endcase
      alu_zf = (alu_y == 32'd0);
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  m;
      logic [31:0] y;
      logic [3:0]  flags;
      logic [2:0]  stat;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"},  32'(cmd_ready), 32'd1);
      chk({tag, "_res_valid"},  32'(res_valid), 32'd0);
      chk({tag, "_res_y"},      res_y, 32'd0);
      chk({tag, "_res_flags"},  32'(res_flags), 32'd0);
      chk({tag, "_stat_flags"}, 32'(stat_flags), 32'd0);
      chk({tag, "_op_count"},   32'(op_count), 32'd0);
      chk({tag, "_alu_a"},      alu_a, 32'd0);
      chk({tag, "_alu_b"},      alu_b, 32'd0);
      chk({tag, "_alu_m"},      32'(alu_m), 32'd0);
   endtask

   // One command end to end; hold = extra cycles with res_ready low and a competing command offered
   task automatic do_cmd(input vec_t v, input int hold);
      int w;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_a     = v.a;
      cmd_b     = v.b;
      w = 0;
      while (!cmd_ready && w < 20) begin
         tick();
         w++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      tick();                                   // edge N: accept
      cmd_valid = 1'b0;
      chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("exec_alu_a", alu_a, v.a);
      chk("exec_alu_b", alu_b, v.b);
      chk("exec_alu_m", 32'(alu_m), 32'(v.m));
      tick();                                   // edge N+1
      chk("n1_res_valid", 32'(res_valid), 32'd0);
      tick();                                   // edge N+2
      chk("n2_res_valid", 32'(res_valid), 32'd1);
      chk("res_y", res_y, v.y);
      chk("res_flags", 32'(res_flags), 32'(v.flags));
      chk("stat_flags", 32'(stat_flags), 32'(v.stat));
      chk("op_count", 32'(op_count), 32'(v.cnt));
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 3'b001;
         cmd_a     = 32'h1234;
         cmd_b     = 32'h1;
         tick();
         chk("hold_res_valid", 32'(res_valid), 32'd1);
         chk("hold_res_y", res_y, v.y);
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_op_count", 32'(op_count), 32'(v.cnt));
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("done_res_valid", 32'(res_valid), 32'd0);
      chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_alu_a_hold", alu_a, v.a);
      chk("idle_alu_m_hold", 32'(alu_m), 32'(v.m));
   endtask

   initial begin
      //          op      a             b             m       y             flags    stat    cnt
      vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 4'b0011, 3'b011, 16'd1};
      vecs[1]  = '{3'b001, 32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 4'b0100, 3'b100, 16'd2};
      vecs[2]  = '{3'b101, 32'd5,        32'd5,        3'b001, 32'h00000000, 4'b0001, 3'b001, 16'd3};
      vecs[3]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 3'b000, 32'h00000001, 4'b0010, 3'b010, 16'd4};
      vecs[4]  = '{3'b100, 32'hF0F0F0F0, 32'hFFFFFFFF, 3'b100, 32'h0F0F0F0F, 4'b0000, 3'b000, 16'd5};
      vecs[5]  = '{3'b010, 32'h0F0F0F0F, 32'hF0F0F0F0, 3'b010, 32'h00000000, 4'b0001, 3'b001, 16'd6};
      vecs[6]  = '{3'b110, 32'd1,        32'd2,        3'b000, 32'h00000000, 4'b1000, 3'b001, 16'd6};
      vecs[7]  = '{3'b011, 32'h12340000, 32'h00005678, 3'b011, 32'h12345678, 4'b0000, 3'b000, 16'd7};
      vecs[8]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 4'b1000, 3'b000, 16'd7};
      vecs[9]  = '{3'b001, 32'd3,        32'd5,        3'b001, 32'hFFFFFFFE, 4'b0010, 3'b010, 16'd8};
      vecs[10] = '{3'b101, 32'd3,        32'd7,        3'b001, 32'h00000000, 4'b0010, 3'b010, 16'd9};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;
      sc_inc    = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #4;

      // Saturating counter: 3-bit instance stuck at 7 after 10 increments
      sc_inc = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      sc_inc = 1'b0;
      chk("sat_count", 32'(sc_count), 32'd7);

      for (int i = 0; i < 11; i++) do_cmd(vecs[i], 0);

      // Backpressure: 1+1 held for 10 cycles with another command offered
      do_cmd('{3'b000, 32'd1, 32'd1, 3'b000, 32'd2, 4'b0000, 3'b000, 16'd10}, 10);

      // Reset pulse mid-EXEC discards the command
      cmd_valid = 1'b1;
      cmd_op    = 3'b000;
      cmd_a     = 32'd40;
      cmd_b     = 32'd2;
      tick();
      cmd_valid = 1'b0;
      chk("pre_rst_in_exec", 32'(cmd_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_exec_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #4;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_resp", 32'(res_valid), 32'd0);
      end
      do_cmd('{3'b001, 32'd10, 32'd3, 3'b001, 32'd7, 4'b0000, 3'b000, 16'd1}, 0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
